// File: rtl/planta_pkg.sv
// planta_pkg: shared definitions for the watering path.
//   - estado_t: pump controller state encodings as seen on the estado output.
//   - TipoMin/TipoMax: valid plant-type range.
//   - mult_riego(): duration multiplier for a plant type (0 for invalid types).
//     The threshold logic also uses it.
package planta_pkg;

    typedef enum logic [1:0] {
        StReposo  = 2'd0,
        StRegando = 2'd1,
        StEspera  = 2'd2,
        StFalla   = 2'd3
    } estado_t;

    localparam logic [3:0] TipoMin   = 4'd1;
    localparam logic [3:0] TipoMax   = 4'd3;
    localparam logic [3:0] CiclosSat = 4'd15;

    // Multiplier applied to the base watering time; 0 marks a type that never waters.
    function automatic int unsigned mult_riego(input logic [3:0] tipo);
        if (tipo >= TipoMin && tipo <= TipoMax) begin
            return {28'd0, tipo};
        end
        return 0;
    endfunction

    function automatic logic tipo_valido(input logic [3:0] tipo);
        return mult_riego(tipo) != 0;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: prescaler producing a one-cycle tick every TICK_DIV clocks.
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear; the next tick comes TICK_DIV cycles later
//   tick out  one-cycle pulse
module divisor_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_bomba.sv
// control_bomba: pump driver for the watering request.
// Runs the pump for tipoPlanta*RIEGO_S ticks, soaks for ESPERA_S ticks, then
// re-checks regar. Optional fault lockout with macro CONTROL_BOMBA_FALLA_EN.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   regar       in   watering request (level)
//   tipoPlanta  in   plant type, 1..3 valid
//   habilitar   in   master enable, low aborts watering
//   rearme      in   clears FALLA
//   bomba       out  pump relay drive (registered)
//   estado      out  current state (0 REPOSO, 1 REGANDO, 2 ESPERA, 3 FALLA)
//   ciclos      out  consecutive pulses in the current request
//   falla       out  high while in FALLA
module control_bomba
    import planta_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned RIEGO_S    = 5,
    parameter int unsigned ESPERA_S   = 30,
    parameter int unsigned MAX_CICLOS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       regar,
    input  logic [3:0] tipoPlanta,
    input  logic       habilitar,
    input  logic       rearme,
    output logic       bomba,
    output logic [1:0] estado,
    output logic [3:0] ciclos,
    output logic       falla
);

    localparam int unsigned MaxS = (RIEGO_S > ESPERA_S) ? RIEGO_S : ESPERA_S;
    localparam int unsigned CntW = $clog2(3 * MaxS + 1);

    estado_t         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      ciclos_q, ciclos_d;
    logic [3:0]      tipo_q, tipo_d;
    logic            bomba_q;
    logic            tick;
    logic            limite;

    // Clearing on every state change makes each timed state exactly N*TICK_DIV long.
    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .tick (tick)
    );

    assign limite = (ciclos_q >= 4'(MAX_CICLOS));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ciclos_d = ciclos_q;
        tipo_d   = tipo_q;
        case (state_q)
            StReposo: begin
                ciclos_d = '0;
                if (habilitar && regar && tipo_valido(tipoPlanta)) begin
                    state_d = StRegando;
                    tipo_d  = tipoPlanta;
                    cnt_d   = CntW'(mult_riego(tipoPlanta) * RIEGO_S);
                end
            end
            StRegando: begin
                // Enable loss wins over a tick expiring on the same cycle.
                if (!habilitar) begin
                    state_d  = StReposo;
                    ciclos_d = '0;
                end else if (tick) begin
                    if (cnt_q == CntW'(1)) begin
                        state_d  = StEspera;
                        cnt_d    = CntW'(ESPERA_S);
                        ciclos_d = (ciclos_q == CiclosSat) ? ciclos_q : ciclos_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StEspera: begin
                if (!habilitar) begin
                    state_d  = StReposo;
                    ciclos_d = '0;
                end else if (tick) begin
                    if (cnt_q == CntW'(1)) begin
                        if (!regar) begin
                            state_d  = StReposo;
                            ciclos_d = '0;
                        end else
`ifdef CONTROL_BOMBA_FALLA_EN
                        if (limite) begin
                            state_d = StFalla;
                        end else
`endif
                        begin
                            state_d = StRegando;
                            cnt_d   = CntW'(mult_riego(tipo_q) * RIEGO_S);
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StFalla: begin
`ifdef CONTROL_BOMBA_FALLA_EN
                if (rearme) begin
                    state_d  = StReposo;
                    ciclos_d = '0;
                end
`else
                state_d  = StReposo;
                ciclos_d = '0;
`endif
            end
            default: begin
                state_d  = StReposo;
                ciclos_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StReposo;
            cnt_q    <= '0;
            ciclos_q <= '0;
            tipo_q   <= '0;
            bomba_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ciclos_q <= ciclos_d;
            tipo_q   <= tipo_d;
            bomba_q  <= (state_d == StRegando);
        end
    end

    assign bomba  = bomba_q;
    assign estado = state_q;
    assign ciclos = ciclos_q;

`ifdef CONTROL_BOMBA_FALLA_EN
    logic falla_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            falla_q <= 1'b0;
        end else begin
            falla_q <= (state_d == StFalla);
        end
    end

    assign falla = falla_q;
`else
    // Without lockout rearme and the pulse limit have no effect.
    logic unused_cfg;
    assign unused_cfg = rearme ^ limite;
    assign falla = 1'b0;
`endif

endmodule

// File: tb/tb_control_bomba.sv
module tb_control_bomba;

    logic       clk = 1'b0;
    logic       rst;
    logic       regar;
    logic [3:0] tipoPlanta;
    logic       habilitar;
    logic       rearme;
    logic       bomba;
    logic [1:0] estado;
    logic [3:0] ciclos;
    logic       falla;

    control_bomba #(
        .TICK_DIV   (4),
        .RIEGO_S    (2),
        .ESPERA_S   (3),
        .MAX_CICLOS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .regar      (regar),
        .tipoPlanta (tipoPlanta),
        .habilitar  (habilitar),
        .rearme     (rearme),
        .bomba      (bomba),
        .estado     (estado),
        .ciclos     (ciclos),
        .falla      (falla)
    );

    always #5 clk = ~clk;

    // Expected output change: {estado, bomba, ciclos, falla} and cycles spent in
    // the previous output value (0 = not checked).
    typedef struct {
        logic [7:0] v;
        int         dt;
        string      name;
    } ev_t;

    ev_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic       mon_en   = 1'b0;
    logic [7:0] prev;
    int         cyc;

    function automatic void expect_ev(input string n, input logic [1:0] e, input logic b,
                                      input logic [3:0] c, input logic f, input int dt);
        ev_t x;
        x.v    = {e, b, c, f};
        x.dt   = dt;
        x.name = n;
        exp_q.push_back(x);
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", n, got, want);
        end
    endtask

    // Monitor: every change on the outputs pops one expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] cur;
            ev_t        e;
            cyc++;
            cur = {estado, bomba, ciclos, falla};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change got=%h prev=%h", cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.v) begin
                        failures++;
                        $display("FAIL %s got est/bomba/ciclos/falla=%h expected=%h",
                                 e.name, cur, e.v);
                    end
                    if (e.dt != 0) begin
                        checks++;
                        if (cyc != e.dt) begin
                            failures++;
                            $display("FAIL %s_len got=%0d cycles expected=%0d",
                                     e.name, cyc, e.dt);
                        end
                    end
                end
                prev = cur;
                cyc  = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string n);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk({n, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        step(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; regar = 1'b0; tipoPlanta = 4'd0; habilitar = 1'b1; rearme = 1'b0;
        step(2);
        chk("rst_bomba", bomba, 0);
        chk("rst_estado", estado, 0);
        chk("rst_ciclos", ciclos, 0);
        chk("rst_falla", falla, 0);
        rst = 1'b0;
        prev = 8'h00; cyc = 0; mon_en = 1'b1;
        step(2);

        // 1: tipo 1, regar held; rearme ignored outside FALLA.
        expect_ev("t1_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t1_espera", 2'd2, 1'b0, 4'd1, 1'b0, 8);
        expect_ev("t1_reposo", 2'd0, 1'b0, 4'd0, 1'b0, 12);
        tipoPlanta = 4'd1; regar = 1'b1; rearme = 1'b1;
        step(15);
        regar = 1'b0;
        wait_idle("t1");
        rearme = 1'b0;

        // 2: tipo 3, one-cycle request.
        expect_ev("t2_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t2_espera", 2'd2, 1'b0, 4'd1, 1'b0, 24);
        expect_ev("t2_reposo", 2'd0, 1'b0, 4'd0, 1'b0, 12);
        tipoPlanta = 4'd3; regar = 1'b1;
        step(1);
        regar = 1'b0;
        wait_idle("t2");

        // 3: tipo 2, regar held.
        expect_ev("t3_regando1", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t3_espera1", 2'd2, 1'b0, 4'd1, 1'b0, 16);
        expect_ev("t3_regando2", 2'd1, 1'b1, 4'd1, 1'b0, 12);
        expect_ev("t3_espera2", 2'd2, 1'b0, 4'd2, 1'b0, 16);
`ifdef CONTROL_BOMBA_FALLA_EN
        expect_ev("t3_falla", 2'd3, 1'b0, 4'd2, 1'b1, 12);
        tipoPlanta = 4'd2; regar = 1'b1;
        wait_idle("t3");
        step(5);
        chk("t3_falla_hold", falla, 1);
        chk("t3_bomba_off", bomba, 0);
        expect_ev("t3_rearme", 2'd0, 1'b0, 4'd0, 1'b0, 0);
        rearme = 1'b1; regar = 1'b0;
        step(1);
        chk("t3_rearme_estado", estado, 0);
        chk("t3_rearme_falla", falla, 0);
        rearme = 1'b0;
        wait_idle("t3r");
`else
        expect_ev("t3_regando3", 2'd1, 1'b1, 4'd2, 1'b0, 12);
        expect_ev("t3_espera3", 2'd2, 1'b0, 4'd3, 1'b0, 16);
        expect_ev("t3_reposo", 2'd0, 1'b0, 4'd0, 1'b0, 12);
        tipoPlanta = 4'd2; regar = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 1; i++) @(posedge clk);
        #1;
        chk("t3_no_falla", falla, 0);
        regar = 1'b0;
        wait_idle("t3");
`endif

        // 4: invalid plant types never water.
        begin
            logic [3:0] bad [3];
            bad[0] = 4'd0; bad[1] = 4'd7; bad[2] = 4'd4;
            for (int i = 0; i < 3; i++) begin
                tipoPlanta = bad[i]; regar = 1'b1;
                step(10);
                chk("t4_estado", estado, 0);
                chk("t4_bomba", bomba, 0);
            end
            regar = 1'b0;
            step(2);
        end

        // 5a: habilitar dropped on cycle 5 of a pulse.
        expect_ev("t5a_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t5a_abort", 2'd0, 1'b0, 4'd0, 1'b0, 5);
        tipoPlanta = 4'd1; regar = 1'b1;
        step(5);
        habilitar = 1'b0; regar = 1'b0;
        step(1);
        chk("t5a_bomba", bomba, 0);
        chk("t5a_ciclos", ciclos, 0);
        wait_idle("t5a");
        habilitar = 1'b1;
        step(2);

        // 5b: habilitar dropped on the same cycle as the expiry tick.
        expect_ev("t5b_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t5b_abort", 2'd0, 1'b0, 4'd0, 1'b0, 8);
        regar = 1'b1;
        step(8);
        habilitar = 1'b0; regar = 1'b0;
        wait_idle("t5b");
        habilitar = 1'b1;
        step(2);

        // 5c: habilitar dropped during ESPERA clears ciclos.
        expect_ev("t5c_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t5c_espera", 2'd2, 1'b0, 4'd1, 1'b0, 8);
        expect_ev("t5c_abort", 2'd0, 1'b0, 4'd0, 1'b0, 4);
        regar = 1'b1;
        step(1);
        regar = 1'b0;
        step(11);
        habilitar = 1'b0;
        wait_idle("t5c");
        habilitar = 1'b1;
        step(2);

        // 6a: rst mid-pulse stops the pump on that edge.
        expect_ev("t6a_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t6a_rst", 2'd0, 1'b0, 4'd0, 1'b0, 3);
        tipoPlanta = 4'd2; regar = 1'b1;
        step(1);
        regar = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        chk("t6a_bomba", bomba, 0);
        chk("t6a_estado", estado, 0);
        rst = 1'b0;
        wait_idle("t6a");

        // 6b: tipoPlanta change mid-pulse is ignored.
        expect_ev("t6b_regando", 2'd1, 1'b1, 4'd0, 1'b0, 0);
        expect_ev("t6b_espera", 2'd2, 1'b0, 4'd1, 1'b0, 8);
        expect_ev("t6b_reposo", 2'd0, 1'b0, 4'd0, 1'b0, 12);
        tipoPlanta = 4'd1; regar = 1'b1;
        step(1);
        regar = 1'b0;
        step(1);
        tipoPlanta = 4'd3;
        wait_idle("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
